// File: rtl/icache_sram_sequencer.sv
// icache_sram_sequencer: arbitrates fetch reads and refill writes onto one single-port line SRAM
// and zero-clears the whole array after reset and on flush.
module icache_sram_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256,
  parameter int DEPTH = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              volt_sel_cfg,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              clear_done,
  output logic              sram_valid,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_volt_sel
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t INIT = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state;
  logic [ADDR_W-1:0] clr_cnt;
  logic last_write;
  // a contested cycle goes to whichever side did not win the previous grant
  assign busy = state == CLEAR;
  assign rd_ready = !busy && rd_valid && (!wr_valid || last_write);
  assign wr_ready = !busy && wr_valid && !rd_ready;
  assign sram_valid = busy || rd_ready || wr_ready;
  assign sram_write = busy || wr_ready;
  assign sram_addr = busy ? clr_cnt : wr_ready ? wr_addr : rd_ready ? rd_addr : '0;
  assign sram_wdata = wr_ready ? wr_data : '0;
  assign rsp_data = sram_rdata;
  assign sram_volt_sel = volt_sel_cfg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      clr_cnt <= '0;
      last_write <= 1'b1;
      rsp_valid <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      rsp_valid <= rd_ready;
      clear_done <= 1'b0;
      if (rd_ready) last_write <= 1'b0;
      else if (wr_ready) last_write <= 1'b1;
      if (busy) begin
        if (flush) clr_cnt <= '0;
        else if (clr_cnt == LAST) begin
          state <= RUN;
          clr_cnt <= '0;
          clear_done <= 1'b1;
        end else clr_cnt <= clr_cnt + 1'b1;
      end else if (flush) begin
        state <= CLEAR;
        clr_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_icache_sram_sequencer.sv
// tb_icache_sram_sequencer: directed scenarios plus randomized traffic checked every cycle
// against a line-array model of the cache contents and arbitration rules.
module tb_icache_sram_sequencer;
  logic clock = 0, reset = 1, flush = 0, volt_sel_cfg = 0;
  logic rd_valid = 0, wr_valid = 0;
  logic [7:0] rd_addr = 0, wr_addr = 0;
  logic [255:0] wr_data = 0;
  logic rd_ready, wr_ready, rsp_valid, busy, clear_done;
  logic sram_valid, sram_write, sram_volt_sel;
  logic [7:0] sram_addr;
  logic [255:0] rsp_data, sram_wdata, sram_rdata;
  int passed = 0, total = 0;

  icache_sram_sequencer #(.ADDR_W(8), .DATA_W(256), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .volt_sel_cfg(volt_sel_cfg),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .clear_done(clear_done),
    .sram_valid(sram_valid), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_volt_sel(sram_volt_sel));

  always #5 clock = ~clock;

  // SRAM macro: one access per cycle, read data held until the next read
  logic [255:0] sram_mem [256];
  always @(posedge clock) begin
    if (sram_valid && sram_write) sram_mem[sram_addr] <= sram_wdata;
    else if (sram_valid) sram_rdata <= sram_mem[sram_addr];
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: array contents, clear progress, arbitration history
  logic [255:0] ref_mem [256];
  bit m_clear = 1, m_lastw = 1, m_rsp = 0, m_done = 0;
  int m_idx = 0;
  logic [255:0] m_rsp_data = 0;

  always @(negedge clock) begin
    bit r, w;
    check("volt_sel", 256'(sram_volt_sel), 256'(volt_sel_cfg));
    if (reset) begin
      m_clear = 1; m_idx = 0; m_lastw = 1; m_rsp = 0; m_done = 0;
      check("rst_busy", 256'(busy), 256'(1));
      check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
      check("rst_clear_done", 256'(clear_done), 256'(0));
      check("rst_ready", 256'({rd_ready, wr_ready}), 256'(0));
    end else begin
      r = !m_clear && rd_valid && (!wr_valid || m_lastw);
      w = !m_clear && wr_valid && !r;
      check("busy", 256'(busy), 256'(m_clear));
      check("rd_ready", 256'(rd_ready), 256'(r));
      check("wr_ready", 256'(wr_ready), 256'(w));
      check("sram_valid", 256'(sram_valid), 256'(m_clear || r || w));
      check("sram_write", 256'(sram_write), 256'(m_clear || w));
      if (m_clear) begin
        check("clr_addr", 256'(sram_addr), 256'(m_idx));
        check("clr_wdata", sram_wdata, 256'(0));
      end else if (w) begin
        check("wr_addr", 256'(sram_addr), 256'(wr_addr));
        check("wr_wdata", sram_wdata, wr_data);
      end else if (r) check("rd_addr", 256'(sram_addr), 256'(rd_addr));
      check("rsp_valid", 256'(rsp_valid), 256'(m_rsp));
      if (m_rsp) check("rsp_data", rsp_data, m_rsp_data);
      check("clear_done", 256'(clear_done), 256'(m_done));
      m_done = 0;
      m_rsp = r;
      if (r) m_rsp_data = ref_mem[rd_addr];
      if (w) ref_mem[wr_addr] = wr_data;
      if (r) m_lastw = 0;
      if (w) m_lastw = 1;
      if (m_clear) begin
        ref_mem[m_idx] = 0;
        if (flush) m_idx = 0;
        else if (m_idx == 255) begin m_clear = 0; m_idx = 0; m_done = 1; end
        else m_idx++;
      end else if (flush) begin
        m_clear = 1; m_idx = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    rd_valid = 0; wr_valid = 0; flush = 0;
  endtask

  task automatic wait_clear_done(output int n);
    n = 0;
    while (!clear_done && n < 1000) begin step(); n++; end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [255:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d; step(); idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    rd_valid = 1; rd_addr = a; step(); idle();
  endtask

  initial begin
    int n, rst_hold;
    logic [5:0] pat;
    logic [255:0] a5, d40;
    for (int i = 0; i < 256; i++) sram_mem[i] = rand256();
    a5 = {32{8'hA5}};
    d40 = rand256();
    repeat (3) step();
    reset = 0;
    n = 0;
    while (busy && n < 1000) begin step(); n++; end
    check("clear_len", 256'(n), 256'(256));
    check("clear_done_pulse", 256'(clear_done), 256'(1));
    rd_valid = 1; #1;
    check("rd_follows_valid", 256'(rd_ready), 256'(1));
    idle();
    do_write(8'h12, a5);
    do_read(8'h12);
    check("lit_rsp_valid", 256'(rsp_valid), 256'(1));
    check("lit_rsp_a5", rsp_data, a5);
    do_read(8'h13);
    check("lit_rsp_zero", rsp_data, 256'(0));
    do_write(8'h20, rand256());
    rd_valid = 1; wr_valid = 1; rd_addr = 8'h21; wr_addr = 8'h22; wr_data = rand256();
    for (int i = 5; i >= 0; i--) begin
      #1;
      pat[i] = rd_ready;
      check("never_both", 256'(rd_ready & wr_ready), 256'(0));
      step();
    end
    idle();
    check("rr_pattern", 256'(pat), 256'(6'b101010));
    do_write(8'h40, d40);
    rd_valid = 1; rd_addr = 8'h40; flush = 1; step(); idle();
    check("flush_rsp_valid", 256'(rsp_valid), 256'(1));
    check("flush_rsp_old", rsp_data, d40);
    check("flush_busy", 256'(busy), 256'(1));
    repeat (100) step();
    check("clr_at_100", 256'(sram_addr), 256'(100));
    flush = 1; step(); flush = 0;
    check("clr_restart", 256'(sram_addr), 256'(0));
    wait_clear_done(n);
    check("flush_clear_len", 256'(n), 256'(256));
    do_read(8'h40);
    check("post_clear_zero", rsp_data, 256'(0));
    do_read(8'h40);
    #1 reset = 1; #1;
    check("rst_drops_rsp", 256'(rsp_valid), 256'(0));
    step(); reset = 0;
    repeat (50) step();
    check("clr_at_50", 256'(sram_addr), 256'(50));
    #1 reset = 1; #1;
    check("rst_clr_zero", 256'(sram_addr), 256'(0));
    step(); reset = 0;
    step();
    check("clr_from_1", 256'(sram_addr), 256'(1));
    wait_clear_done(n);
    check("clear_after_rst", 256'(n), 256'(255));
    rst_hold = 0;
    for (int c = 0; c < 5000; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 0;
      end else if ($urandom_range(1999) == 0) begin
        reset = 1; rst_hold = $urandom_range(3, 1);
      end
      rd_valid = 1'($urandom_range(1));
      wr_valid = 1'($urandom_range(1));
      rd_addr = 8'($urandom_range(15));
      wr_addr = 8'($urandom_range(15));
      wr_data = rand256();
      flush = ($urandom_range(599) == 0);
      volt_sel_cfg = 1'($urandom_range(1));
      step();
    end
    reset = 0; idle();
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
